// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Moore outputs from the state register, an instret counter and a sticky illegal-instruction trap.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             memWrite,
  output logic             irWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       immSrc,
  output logic             regWrite,
  output logic [2:0]       ALUcontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       funct_alu;
  logic             funct_ok;

  always_comb begin
    immSrc = 2'b00;
    case (op)
      7'b0100011: immSrc = 2'b01;
      7'b1100011: immSrc = 2'b10;
      7'b1101111: immSrc = 2'b11;
      default:    immSrc = 2'b00;
    endcase
  end

  // sub only for R-type with funct7b5; I-type addi never subtracts
  always_comb begin
    funct_alu = 3'b000;
    funct_ok  = 1'b1;
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    instret_d  = instret_q;
    illegal_d  = illegal_q;
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    regWrite   = 1'b0;
    ALUcontrol = 3'b000;
    case (state_q)
      FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = memReady;
        pcWrite   = memReady;
        if (memReady) state_d = DECODE;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BEQ;
          7'b1101111:             state_d = JAL;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) state_d = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = FETCH;
      end
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (memReady) begin
          instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d   = FETCH;
        end
      end
      EXECR: begin
        aluSrcA    = 2'b10;
        ALUcontrol = funct_alu;
        state_d    = funct_ok ? ALUWB : TRAP;
      end
      EXECI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        ALUcontrol = funct_alu;
        state_d    = funct_ok ? ALUWB : TRAP;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = FETCH;
      end
      BEQ: begin
        aluSrcA    = 2'b10;
        ALUcontrol = 3'b001;
        pcWrite    = zero;
        instret_d  = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d    = FETCH;
      end
      JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // illegal rises together with entry into TRAP so it is already 1 in the TRAP cycle
    if (state_d == TRAP) illegal_d = 1'b1;
    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle control
// trace from the instruction-class rules, then replayed against the DUT with random stalls.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       op = 7'd0;
  logic [2:0]       funct3 = 3'd0;
  logic             funct7b5 = 1'b0;
  logic             zero = 1'b0;
  logic             memReady = 1'b1;
  logic             pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0]       resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]       ALUcontrol;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .irWrite(irWrite), .resultSrc(resultSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc), .regWrite(regWrite),
    .ALUcontrol(ALUcontrol), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] vec;
    logic        mr;
    logic        ill;
    logic        ret;
  } ent_t;

  ent_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   inst_m  = 0;
  int   retired_since_reset = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // expected {pcWrite,adrSrc,memWrite,irWrite,resultSrc,aluSrcA,aluSrcB,immSrc,regWrite,ALUcontrol}
  function automatic logic [15:0] cv(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic rw, input logic [2:0] alu);
    return {pc, adr, mw, ir, rs, a, b, imm_of(op), rw, alu};
  endfunction

  function automatic ent_t mk(input logic [15:0] v, input logic m, input logic il, input logic r);
    ent_t e;
    e.vec = v; e.mr = m; e.ill = il; e.ret = r;
    return e;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ALU operation required for an R/I instruction, plus whether funct3 is supported
  function automatic logic [3:0] alu_rule(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return {1'b1, (o == OP_R && f7) ? 3'b001 : 3'b000};
      3'b010:  return {1'b1, 3'b101};
      3'b110:  return {1'b1, 3'b011};
      3'b111:  return {1'b1, 3'b010};
      default: return {1'b0, 3'b000};
    endcase
  endfunction

  task automatic push_trap();
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(16'h0 | cv(0,0,0,0,0,0,0,0,0), rnd_bit(), 1'b1, 1'b0));
  endtask

  // expand one instruction (op/funct already driven) into its cycle trace; returns 1 if it traps
  task automatic build(input int fstall, input int mstall, output logic trapped);
    logic [3:0] ar;
    trapped = 1'b0;
    for (int i = 0; i < fstall; i++) exp_q.push_back(mk(cv(0,0,0,0,2,0,2,0,0), 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(cv(1,0,0,1,2,0,2,0,0), 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(cv(0,0,0,0,0,1,1,0,0), rnd_bit(), 1'b0, 1'b0));
    case (op)
      OP_LW: begin
        exp_q.push_back(mk(cv(0,0,0,0,0,2,1,0,0), rnd_bit(), 1'b0, 1'b0));
        for (int i = 0; i < mstall; i++) exp_q.push_back(mk(cv(0,1,0,0,0,0,0,0,0), 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(cv(0,1,0,0,0,0,0,0,0), 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(cv(0,0,0,0,1,0,0,1,0), rnd_bit(), 1'b0, 1'b1));
      end
      OP_SW: begin
        exp_q.push_back(mk(cv(0,0,0,0,0,2,1,0,0), rnd_bit(), 1'b0, 1'b0));
        for (int i = 0; i < mstall; i++) exp_q.push_back(mk(cv(0,1,1,0,0,0,0,0,0), 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(cv(0,1,1,0,0,0,0,0,0), 1'b1, 1'b0, 1'b1));
      end
      OP_R, OP_I: begin
        ar = alu_rule(op, funct3, funct7b5);
        exp_q.push_back(mk(cv(0,0,0,0,0,2,(op == OP_R) ? 2'd0 : 2'd1,0,ar[2:0]), rnd_bit(), 1'b0, 1'b0));
        if (ar[3]) exp_q.push_back(mk(cv(0,0,0,0,0,0,0,1,0), rnd_bit(), 1'b0, 1'b1));
        else begin push_trap(); trapped = 1'b1; end
      end
      OP_BEQ: exp_q.push_back(mk(cv(zero,0,0,0,0,2,0,0,3'b001), rnd_bit(), 1'b0, 1'b1));
      OP_JAL: begin
        exp_q.push_back(mk(cv(1,0,0,0,0,1,2,0,0), rnd_bit(), 1'b0, 1'b0));
        exp_q.push_back(mk(cv(0,0,0,0,0,0,0,1,0), rnd_bit(), 1'b0, 1'b1));
      end
      default: begin push_trap(); trapped = 1'b1; end
    endcase
  endtask

  task automatic replay();
    ent_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      memReady = e.mr;
      @(negedge clk);
      check_eq("ctl", {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                       immSrc, regWrite, ALUcontrol}, e.vec);
      check_eq("illegal", illegal, e.ill);
      check_eq("instret", 32'(instret), inst_m);
      @(posedge clk); #1;
      if (e.ret) begin
        inst_m = (inst_m + 1) % (1 << CNT_W);
        retired_since_reset++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    memReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("reset_en", {pcWrite, irWrite, regWrite, memWrite}, 4'b0000);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    inst_m = 0;
    retired_since_reset = 0;
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input int fs, input int ms);
    logic t;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(fs, ms, t);
    replay();
    if (t) do_reset(1);
  endtask

  initial begin
    logic [6:0] bad_ops [3];
    logic [2:0] ok_f3 [4];
    logic [2:0] bad_f3 [4];
    logic [6:0] o;
    logic [2:0] f3;
    int k;
    bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111};
    ok_f3   = '{3'b000, 3'b010, 3'b110, 3'b111};
    bad_f3  = '{3'b001, 3'b011, 3'b100, 3'b101};
    #1;
    do_reset(3);
    run(OP_R,   3'b000, 1'b1, 1'b0, 0, 0);
    run(OP_LW,  3'b010, 1'b0, 1'b0, 0, 2);
    run(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_SW,  3'b010, 1'b0, 1'b0, 1, 1);
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 18; i++) run(OP_BEQ, 3'b000, 1'b0, rnd_bit(), 0, 0);
    check_eq("wrap_seen", 32'(retired_since_reset >= (1 << CNT_W)), 32'd1);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 11);
      case (k)
        0, 1:    o = OP_LW;
        2, 3:    o = OP_SW;
        4, 5:    o = OP_R;
        6, 7:    o = OP_I;
        8, 9:    o = OP_BEQ;
        10:      o = OP_JAL;
        default: o = bad_ops[$urandom_range(0, 2)];
      endcase
      f3 = ($urandom_range(0, 7) == 0) ? bad_f3[$urandom_range(0, 3)] : ok_f3[$urandom_range(0, 3)];
      run(o, f3, rnd_bit(), rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the multicycle variant of the RV32I-subset datapath. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
- Decodes op/funct3/funct7b5 from the instruction register.
- Drives all mux selects and write enables each cycle.
- Counts retired instructions and traps on illegal opcodes.
- Sits beside the datapath, replacing the combinational single-cycle decoder.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- memReady  in  1  unified memory access completes this cycle
- pcWrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0=PC, 1=result
- memWrite  out  1  memory write enable
- irWrite  out  1  instruction register and oldPC enable
- resultSrc  out  2  result select: 00=aluOut, 01=readData, 10=aluResult
- aluSrcA  out  2  ALU A select: 00=PC, 01=oldPC, 10=rd1 register
- aluSrcB  out  2  ALU B select: 00=rd2 register, 01=immExt, 10=constant 4
- immSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- regWrite  out  1  register file write enable
- ALUcontrol  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- State register encoding and sequencing:
  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
  - Synchronous reset: state<=FETCH, instret<=0, illegal<=0.
  - While reset=1, pcWrite, irWrite, regWrite and memWrite are forced to 0.
- Outputs are Moore from state (memReady/zero gating noted). Unlisted signals are 0; selects are 00 where not listed.
- FETCH:
  - adrSrc=0, aluSrcA=00, aluSrcB=10, ALU op add, resultSrc=10.
  - irWrite=pcWrite=memReady.
  - Next state: DECODE if memReady, else FETCH (stall; no PC or IR change).
- DECODE:
  - aluSrcA=01, aluSrcB=01, add (branch target into aluOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> TRAP.
- MEMADR:
  - aluSrcA=10, aluSrcB=01, add.
  - Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD:
  - adrSrc=1, resultSrc=00.
  - Waits for memReady, then -> MEMWB.
- MEMWB: resultSrc=01, regWrite=1. Next: FETCH.
- MEMWRITE:
  - adrSrc=1, resultSrc=00, memWrite=1 held until memReady.
  - Next: FETCH when memReady.
- EXECR: aluSrcA=10, aluSrcB=00, ALUcontrol from funct decode. Next: ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, ALUcontrol from funct decode. Next: ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Next: FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, sub, resultSrc=00.
  - pcWrite=zero.
  - Next: FETCH.
- JAL:
  - aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1.
  - Next: ALUWB (writes PC+4 to rd).
- TRAP:
  - All enables 0, illegal=1.
  - Stays in TRAP until reset.
- immSrc is decoded combinationally from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Funct decode (EXECR/EXECI):
  - funct3 000: sub if op[5]&funct7b5, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Other funct3 -> TRAP at the end of the execute cycle, with regWrite suppressed.
- instret:
  - Increments by 1 on the last cycle of each instruction: MEMWB, MEMWRITE with memReady, ALUWB, BEQ.
  - Wraps modulo 2^CNT_W.
  - Reset has priority over increment.
- CPI: lw 5, sw 4, R/I 4, beq 3, jal 4, each plus memory stall cycles.

Test Plan:
- Reset held 3 cycles with memReady=1 -> all enables 0 during reset. First cycle after reset: FETCH with irWrite=1, pcWrite=1, aluSrcB=10; instret=0.
- op=0110011, funct3=000, funct7b5=1, memReady=1 -> FETCH, DECODE, EXECR (ALUcontrol=001), ALUWB (regWrite=1); instret 0->1 after 4 cycles.
- lw (op=0000011) with memReady low for 2 cycles in MEMREAD -> state held 3 cycles. MEMWB asserts resultSrc=01, regWrite=1. Total 7 cycles.
- beq (op=1100011): zero=1 -> pcWrite=1 in BEQ; repeat with zero=0 -> pcWrite=0. Both return to FETCH; immSrc=10 throughout.
- jal (op=1101111) -> JAL (pcWrite=1, aluSrcA=01, aluSrcB=10), then ALUWB with regWrite=1; immSrc=11.
- op=1111111 -> TRAP after DECODE; illegal=1 and all enables 0 for 20 cycles. Reset pulse clears illegal and returns to FETCH. Separately, instret preset near 2^CNT_W-1 wraps to 0.
